// File: rtl/nibble_add_seq_if.sv
// Request/result and 4-bit adder handshake bundle for the nibble-serial add sequencer.
interface nibble_add_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;
  logic         ovf;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_c;
  logic         add_v;

  // master: operand source + external ripple adder; slave: the sequencer
  modport master (
    output start, a_in, b_in, cin, add_s, add_c, add_v,
    input  busy, done, sum_out, cout, ovf, add_a, add_b, add_cin
  );

  modport slave (
    input  start, a_in, b_in, cin, add_s, add_c, add_v,
    output busy, done, sum_out, cout, ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/nibble_add_seq.sv
// Multi-precision adder: feeds one nibble pair per clock into an external 4-bit
// ripple adder, chains the carry and publishes the full word plus cout/ovf.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  nibble_add_seq_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_nxt;
  logic             load, step, last;
  logic [W-1:0]     a_q, b_q, sum_q, sum_nxt, sum_out_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       nib_a, nib_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Nibble select for the adder and merge of the returned sum nibble
  always_comb begin
    nib_a   = '0;
    nib_b   = '0;
    sum_nxt = sum_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a               = a_q[4*i +: 4];
        nib_b               = b_q[4*i +: 4];
        sum_nxt[4*i +: 4]   = bus.add_s;
      end
    end
  end

  assign bus.add_a   = (state_q == RUN) ? nib_a   : 4'd0;
  assign bus.add_b   = (state_q == RUN) ? nib_b   : 4'd0;
  assign bus.add_cin = (state_q == RUN) ? carry_q : 1'b0;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.sum_out = sum_out_q;
  assign bus.cout    = cout_q;
  assign bus.ovf     = ovf_q;

  // Published results move only on the final nibble edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      sum_out_q <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      if (load) begin
        a_q     <= bus.a_in;
        b_q     <= bus.b_in;
        carry_q <= bus.cin;
        idx_q   <= '0;
      end
      if (step) begin
        sum_q   <= sum_nxt;
        carry_q <= bus.add_c;
        if (!last) idx_q <= idx_q + IDX_W'(1);
      end
      if (last) begin
        sum_out_q <= sum_nxt;
        cout_q    <= bus.add_c;
        ovf_q     <= bus.add_v;
      end
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq: 4-nibble instance checked every cycle against a
// word-level model, plus a 1-nibble instance with directed checks.
module tb_nibble_add_seq;
  localparam int N4 = 4;

  logic clk = 1'b0;
  logic rst_n;
  bit   go = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  nibble_add_seq_if #(.NIBBLES(4)) if4 ();
  nibble_add_seq_if #(.NIBBLES(1)) if1 ();

  nibble_add_seq #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  nibble_add_seq #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Behavioural 4-bit ripple adder for each instance
  logic [3:0] lo4, lo1;
  assign {if4.add_c, if4.add_s} = {1'b0, if4.add_a} + {1'b0, if4.add_b} + {4'd0, if4.add_cin};
  assign lo4 = {1'b0, if4.add_a[2:0]} + {1'b0, if4.add_b[2:0]} + {3'd0, if4.add_cin};
  assign if4.add_v = lo4[3] ^ if4.add_c;
  assign {if1.add_c, if1.add_s} = {1'b0, if1.add_a} + {1'b0, if1.add_b} + {4'd0, if1.add_cin};
  assign lo1 = {1'b0, if1.add_a[2:0]} + {1'b0, if1.add_b[2:0]} + {3'd0, if1.add_cin};
  assign if1.add_v = lo1[3] ^ if1.add_c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level reference for the 4-nibble instance
  int          ph = 0;  // 0 idle, 1..N4 running, N4+1 done
  logic [15:0] m_a = '0, m_b = '0, e_sum = '0;
  logic        m_cin = 1'b0, e_cout = 1'b0, e_ovf = 1'b0;

  function automatic logic [16:0] full_sum(logic [15:0] a, logic [15:0] b, logic c);
    return {1'b0, a} + {1'b0, b} + 17'(c);
  endfunction

  function automatic logic [3:0] nib(logic [15:0] x, int k);
    logic [15:0] t;
    t = x >> (4 * k);
    return t[3:0];
  endfunction

  function automatic logic carry_into(logic [15:0] a, logic [15:0] b, logic c, int k);
    logic [16:0] mask, t;
    mask = (17'd1 << (4 * k)) - 17'd1;
    t    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 17'(c);
    return t[4 * k];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [16:0] f;
    if (!rst_n) begin
      ph <= 0; m_a <= '0; m_b <= '0; m_cin <= 1'b0;
      e_sum <= '0; e_cout <= 1'b0; e_ovf <= 1'b0;
    end else if (ph == 0) begin
      if (if4.start === 1'b1) begin
        m_a <= if4.a_in; m_b <= if4.b_in; m_cin <= if4.cin; ph <= 1;
      end
    end else if (ph == N4) begin
      f      = full_sum(m_a, m_b, m_cin);
      e_sum  <= f[15:0];
      e_cout <= f[16];
      e_ovf  <= (m_a[15] == m_b[15]) && (f[15] != m_a[15]);
      ph     <= N4 + 1;
    end else if (ph == N4 + 1) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
    end
  end

  always @(negedge clk) begin
    logic eb;
    if (go) begin
      eb = (ph >= 1 && ph <= N4);
      chk("busy",    32'(if4.busy),    32'(eb));
      chk("done",    32'(if4.done),    32'(ph == N4 + 1));
      chk("sum_out", 32'(if4.sum_out), 32'(e_sum));
      chk("cout",    32'(if4.cout),    32'(e_cout));
      chk("ovf",     32'(if4.ovf),     32'(e_ovf));
      chk("add_a",   32'(if4.add_a),   eb ? 32'(nib(m_a, ph - 1)) : 32'd0);
      chk("add_b",   32'(if4.add_b),   eb ? 32'(nib(m_b, ph - 1)) : 32'd0);
      chk("add_cin", 32'(if4.add_cin), eb ? 32'(carry_into(m_a, m_b, m_cin, ph - 1)) : 32'd0);
    end
  end

  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input bit lit, input logic [15:0] xs, input logic xc, input logic xv,
                      input bit poke, input string nm);
    int k, bc;
    @(negedge clk);
    if4.a_in = a; if4.b_in = b; if4.cin = c; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0; if4.a_in = 16'($urandom); if4.b_in = 16'($urandom); if4.cin = 1'($urandom);
    k = 1; bc = 0;
    while (!if4.done && k < 20) begin
      if (if4.busy) bc++;
      if4.start = poke && (k == 2);
      if (poke && k == 2) begin if4.a_in = 16'hAAAA; if4.b_in = 16'h1111; end
      @(negedge clk);
      k++;
    end
    chk({nm, ".latency"}, 32'(k), 32'(N4 + 1));
    chk({nm, ".busy_cycles"}, 32'(bc), 32'(N4));
    if (lit) begin
      chk({nm, ".sum"},  32'(if4.sum_out), 32'(xs));
      chk({nm, ".cout"}, 32'(if4.cout),    32'(xc));
      chk({nm, ".ovf"},  32'(if4.ovf),     32'(xv));
    end
    if (poke) begin if4.start = 1'b1; if4.a_in = 16'h0F0F; if4.b_in = 16'h0F0F; end
    @(negedge clk);
    if4.start = 1'b0;
    chk({nm, ".idle_after"}, 32'({if4.busy, if4.done}), 32'd0);
    if (lit) chk({nm, ".sum_hold"}, 32'(if4.sum_out), 32'(xs));
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [3:0] xs, input logic xc, input logic xv, input string nm);
    int k;
    @(negedge clk);
    if1.a_in = a; if1.b_in = b; if1.cin = c; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0; if1.a_in = 4'($urandom); if1.b_in = 4'($urandom);
    chk({nm, ".add_a"},   32'(if1.add_a),   32'(a));
    chk({nm, ".add_cin"}, 32'(if1.add_cin), 32'(c));
    k = 1;
    while (!if1.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, ".latency"}, 32'(k), 32'd2);
    chk({nm, ".sum"},  32'(if1.sum_out), 32'(xs));
    chk({nm, ".cout"}, 32'(if1.cout),    32'(xc));
    chk({nm, ".ovf"},  32'(if1.ovf),     32'(xv));
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [16:0] rf;
    rst_n = 1'b1;
    if4.start = 1'b0; if4.a_in = '0; if4.b_in = '0; if4.cin = 1'b0;
    if1.start = 1'b0; if1.a_in = '0; if1.b_in = '0; if1.cin = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst.busy",  32'(if4.busy),    32'd0);
    chk("rst.done",  32'(if4.done),    32'd0);
    chk("rst.sum",   32'(if4.sum_out), 32'd0);
    chk("rst.flags", 32'({if4.cout, if4.ovf}), 32'd0);
    chk("rst.add",   32'({if4.add_a, if4.add_b, if4.add_cin}), 32'd0);
    chk("rst.dut1",  32'({if1.busy, if1.done, if1.sum_out}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go    = 1'b1;

    run4(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, "basic");
    run4(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, "ripple");
    run4(16'h7FFF, 16'h0000, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, "posovf");
    run4(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, "negovf");
    run4(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, "ignore_start");

    // Abort mid-run with an asynchronous reset
    @(negedge clk);
    if4.a_in = 16'h1234; if4.b_in = 16'h4321; if4.cin = 1'b0; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy",  32'(if4.busy),    32'd0);
    chk("abort.done",  32'(if4.done),    32'd0);
    chk("abort.sum",   32'(if4.sum_out), 32'd0);
    chk("abort.flags", 32'({if4.cout, if4.ovf}), 32'd0);
    chk("abort.add",   32'({if4.add_a, if4.add_b, if4.add_cin}), 32'd0);
    @(negedge clk);
    chk("abort.no_done", 32'(if4.done), 32'd0);
    rst_n = 1'b1;
    run4(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? ~ra : 16'($urandom);
      rf = full_sum(ra, rb, 1'b1);
      run4(ra, rb, 1'($urandom), 1'b0, 16'd0, 1'b0, 1'b0, 1'(i % 7 == 3), "rand");
    end

    run1(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, "n1_ovf");
    run1(4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 1'b0, "n1_carry");
    run1(4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0, "n1_plain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-precision add sequencer wrapped around the team's 4-bit ripple adder stage. It latches two 4·NIBBLES-bit operands and a carry-in on a start pulse, then feeds one nibble pair per clock into the adder. It consumes the adder's sum, carry and overflow, chains the carry into the next nibble, and presents the assembled word with final carry and signed-overflow flags. It sits directly around the adder: upstream as its operand source, downstream as its result collector.

## Interface
- NIBBLES, 4: number of 4-bit nibbles per operand; operand width W = 4·NIBBLES; legal range 1–16.
- clk  in  1  rising-edge clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  W  operand A; sampled only on an accepted start.
- b_in  in  W  operand B; sampled only on an accepted start.
- cin  in  1  word carry-in; sampled only on an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum_out  out  W  result word; holds until the next completion.
- cout  out  1  carry out of the top nibble.
- ovf  out  1  signed overflow, taken as the adder's v on the top nibble.
- add_a  out  4  adder operand A nibble (bit 0 = adder a1).
- add_b  out  4  adder operand B nibble.
- add_cin  out  1  adder carry-in (adder c1).
- add_s  in  4  adder sum nibble (bit 0 = s1).
- add_c  in  1  adder carry out.
- add_v  in  1  adder overflow (carry into MSB XOR carry out).

## Operation
- States:
  - IDLE: waits for start.
  - RUN: processes one nibble per cycle.
  - DONE: single cycle.
- IDLE → RUN on start=1:
  - Latch a_in/b_in into internal operand registers.
  - Set carry register to cin.
  - Set nibble index idx to 0.
- start outside IDLE is ignored. This includes DONE, so there are no back-to-back starts without one IDLE cycle.
- Adder drive (combinational from registers):
  - In RUN: add_a = A[4·idx+3:4·idx], add_b = B[4·idx+3:4·idx], add_cin = carry register.
  - Outside RUN: add_a, add_b and add_cin are all 0.
- Each RUN clock edge:
  - Write add_s into the sum register nibble idx.
  - carry ← add_c.
  - idx ← idx+1.
- On the edge with idx = NIBBLES−1:
  - Capture cout ← add_c and ovf ← add_v.
  - Copy the assembled sum into sum_out.
  - Go to DONE.
- sum_out, cout and ovf change only on that edge. Intermediate nibbles never appear on sum_out.
- DONE → IDLE unconditionally. done=1 only in DONE.
- Arithmetic: sum_out = (A + B + cin) mod 2^W; cout = bit W of the full sum.
- ovf is 1 iff A and B have equal MSBs and sum_out's MSB differs from them, with cin included in the sum.
- idx is ceil(log2(NIBBLES))-bit wide (minimum 1 bit) and never wraps past NIBBLES−1.

## Timing
- Reset (asynchronous assert, applies immediately):
  - state = IDLE, busy = 0, done = 0.
  - sum_out, cout, ovf all 0.
  - add_a, add_b, add_cin all 0.
  - Internal registers cleared.
- Reset deassertion is synchronous to clk in the parent; the block needs no extra sync stage.
- Reset mid-RUN aborts the operation: no done pulse, and outputs return to reset values.
- Latency: start accepted at edge E0.
  - busy is high after E0 through EN.
  - Results are updated at edge EN (N = NIBBLES).
  - done is high for the cycle between EN and EN+1.
- Start-to-done is NIBBLES+1 edges. Minimum start-to-start spacing is NIBBLES+2 cycles.
- a_in, b_in and cin may change freely after E0 without affecting the operation in flight.
- Adder path: one full 4-bit ripple plus a register setup must close within one clk period.

## Test plan
- NIBBLES=4, A=0x1234, B=0x4321, cin=0 → sum_out=0x5555, cout=0, ovf=0; done exactly 5 edges after start; busy high for 4 cycles.
- A=0xFFFF, B=0x0001, cin=0 → sum_out=0x0000, cout=1, ovf=0; carry ripples through all four nibbles.
- A=0x7FFF, B=0x0000, cin=1 → sum_out=0x8000, cout=0, ovf=1. Then A=0x8000, B=0x8000, cin=0 → sum_out=0x0000, cout=1, ovf=1.
- Pulse start again at RUN cycle 2 and in DONE with different operands → ignored; first result 0x5555 is unaffected; only one done pulse.
- Assert rst_n=0 during RUN cycle 2 → busy, done, sum_out, cout, ovf and add_* go to 0 immediately. A later start with 0x0001+0x0001 completes normally: sum_out=0x0002.
- NIBBLES=1, A=0x7, B=0x1, cin=0 → sum_out=0x8, ovf=1, cout=0, done 2 edges after start.
